imem_loader: RTL and testbench

Boot-time writer for the byte-wide instruction memory: accepts a header (base byte address, word count) and a stream of 32-bit instruction words over a valid/ready handshake. It writes each word into memory as four little-endian byte writes. It holds the MIPS core in stall while loading, and it replaces the `$readmemh` image with a runtime load path. It sits between the host/UART front end and the instruction memory's added write port.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared types for the MIPS boot/instruction-memory path    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    ACCEPT   = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : streams header + 32-bit words into byte-wide imem      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader
  import mips_pkg::*;
#(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done
);

  localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);
  localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
  localparam logic [AW-2:0]     CNT_ONE   = (AW-1)'(1);

  loader_state_t     state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-2:0]     remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WIDTH-1:0]  lane_byte;

  // Header address bits above the memory range are deliberately dropped.
  logic unused_in_bits;
  assign unused_in_bits = ^in_data[31:AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    lane_d      = lane_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = HDR_ADDR;
      end
      HDR_ADDR: begin
        if (in_valid) begin
          base_d  = in_data[AW-1:0];
          state_d = HDR_CNT;
        end
      end
      HDR_CNT: begin
        if (in_valid) begin
          remaining_d = in_data[AW-2:0];
          if (in_data[AW-2:0] == '0) begin
            state_d = DONE;
          end else begin
            ptr_d   = base_q;
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          word_d  = in_data;
          lane_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Pointer wraps naturally at DEPTH since it is exactly AW bits wide.
        ptr_d  = ptr_q + PTR_ONE;
        lane_d = lane_q + LANE_ONE;
        if (lane_q == LANE_LAST) begin
          remaining_d = remaining_q - CNT_ONE;
          state_d     = (remaining_q == CNT_ONE) ? DONE : ACCEPT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Little-endian lane select: lane 0 carries bits [7:0].
  always_comb begin
    lane_byte = '0;
    case (lane_q)
      2'd0:    lane_byte = word_q[WIDTH-1:0];
      2'd1:    lane_byte = word_q[2*WIDTH-1:WIDTH];
      2'd2:    lane_byte = word_q[3*WIDTH-1:2*WIDTH];
      default: lane_byte = word_q[4*WIDTH-1:3*WIDTH];
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      HDR_ADDR, HDR_CNT, ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        wr_addr = ptr_q;
        wr_data = lane_byte;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : directed scoreboard bench for imem_loader           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data  = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;

  logic [15:0]   exp_q[$];
  logic [15:0]   exp_e;
  logic [7:0]    sb_ptr;
  logic [7:0]    mem [DEPTH];
  logic          mem_clr = 1'b0;

  imem_loader #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide instruction memory with its synchronous write port.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next expected byte.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL wr_unexp: observed write %h@%h expected none", wr_data, wr_addr);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("wr_byte", {16'h0, wr_addr, wr_data}, {16'h0, exp_e});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int l = 0; l < 4; l++) begin
      exp_q.push_back({sb_ptr, w[8*l +: 8]});
      sb_ptr = sb_ptr + 8'd1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("hs_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(output int t0);
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    c = cyc;
  endtask

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  initial begin
    int t0, tc, dc0;

    // Reset with noisy inputs; memory image cleared alongside.
    rst_n = 1'b0; mem_clr = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    repeat (3) tick();
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_wr_en",    {31'h0, wr_en},    32'h0);
    check("rst_busy",     {31'h0, busy},     32'h0);
    check("rst_done",     {31'h0, done},     32'h0);
    check("rst_wr_addr",  {24'h0, wr_addr},  32'h0);
    check("rst_wr_data",  {24'h0, wr_data},  32'h0);
    start = 1'b0; in_valid = 1'b0; in_data = '0; mem_clr = 1'b0; rst_n = 1'b1;
    tick();
    check("idle_ready", {31'h0, in_ready}, 32'h0);

    // Basic two-word load.
    pulse_start(t0);
    check("hdr_lat",  {31'h0, in_ready}, 32'h1);
    check("busy_hi",  {31'h0, busy},     32'h1);
    send(32'h0000_0010);
    sb_ptr = 8'h10;
    send(32'h0000_0002);
    push_word(32'h8C01_0004);
    send(32'h8C01_0004);
    push_word(32'h2002_0005);
    send(32'h2002_0005);
    wait_done(tc);
    check("done_lat", tc - t0 + 1, 32'd14);
    check("busy_lo",  {31'h0, busy}, 32'h0);
    tick();
    check("done_1cyc", {31'h0, done}, 32'h0);
    check("rd_w0", rd_word(8'h10), 32'h8C01_0004);
    check("rd_w1", rd_word(8'h14), 32'h2002_0005);

    // Address wrap at the top of memory.
    pulse_start(t0);
    send(32'hFFFF_FFFE);
    sb_ptr = 8'hFE;
    send(32'h0000_0001);
    push_word(32'hAABB_CCDD);
    send(32'hAABB_CCDD);
    wait_done(tc);
    tick();
    check("wrap_fe", {24'h0, mem[8'hFE]}, 32'hDD);
    check("wrap_ff", {24'h0, mem[8'hFF]}, 32'hCC);
    check("wrap_00", {24'h0, mem[8'h00]}, 32'hBB);
    check("wrap_01", {24'h0, mem[8'h01]}, 32'hAA);

    // Zero count: DONE directly after the count handshake, no writes.
    pulse_start(t0);
    send(32'h0000_0020);
    send(32'h0000_0000);
    check("zero_done", {31'h0, done}, 32'h1);
    check("zero_busy", {31'h0, busy}, 32'h0);
    tick();

    // Source stall in ACCEPT.
    pulse_start(t0);
    send(32'h0000_0030);
    sb_ptr = 8'h30;
    send(32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", {31'h0, in_ready}, 32'h1);
      check("stall_wr_en", {31'h0, wr_en},    32'h0);
      tick();
    end
    push_word(32'hCAFE_F00D);
    send(32'hCAFE_F00D);
    wait_done(tc);
    tick();
    check("stall_word", rd_word(8'h30), 32'hCAFE_F00D);

    // Start pulsed mid-load is ignored.
    dc0 = done_cnt;
    pulse_start(t0);
    send(32'h0000_0080);
    sb_ptr = 8'h80;
    send(32'h0000_0002);
    push_word(32'h0123_4567);
    send(32'h0123_4567);
    start = 1'b1;
    tick();
    start = 1'b0;
    push_word(32'h89AB_CDEF);
    send(32'h89AB_CDEF);
    wait_done(tc);
    tick();
    tick();
    check("ign_done_cnt", done_cnt - dc0, 32'd1);
    check("ign_idle",     {31'h0, in_ready}, 32'h0);
    check("ign_w0", rd_word(8'h80), 32'h0123_4567);
    check("ign_w1", rd_word(8'h84), 32'h89AB_CDEF);

    // Reset lands on the edge that would begin lane 2.
    dc0 = done_cnt;
    pulse_start(t0);
    send(32'h0000_0040);
    send(32'h0000_0001);
    exp_q.push_back({8'h40, 8'h44});
    exp_q.push_back({8'h41, 8'h33});
    send(32'h1122_3344);
    tick();
    rst_n = 1'b0;
    tick();
    check("mrst_in_ready", {31'h0, in_ready}, 32'h0);
    check("mrst_wr_en",    {31'h0, wr_en},    32'h0);
    check("mrst_busy",     {31'h0, busy},     32'h0);
    check("mrst_done",     {31'h0, done},     32'h0);
    check("mrst_wr_addr",  {24'h0, wr_addr},  32'h0);
    check("mrst_wr_data",  {24'h0, wr_data},  32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("mrst_no_done", done_cnt - dc0, 32'd0);
    check("mrst_lane0", {24'h0, mem[8'h40]}, 32'h44);
    check("mrst_lane1", {24'h0, mem[8'h41]}, 32'h33);
    check("mrst_lane2", {24'h0, mem[8'h42]}, 32'h00);
    check("mrst_lane3", {24'h0, mem[8'h43]}, 32'h00);

    check("sb_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
